// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: parametrised control-bundle pipeline register
// with per-stage valid, stall hold, flush bubble and occupancy.
module ctrl_pipe_reg #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      DEPTH      = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter bit               NEG_EDGE   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       valid_i,
  output logic [WIDTH-1:0]           q,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] dataNext [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] vNext;
  logic [OW-1:0]    occ;
  logic [OW-1:0]    occNext;
  logic             entering;
  logic             leaving;

  // Valid entry entering stage 0 / leaving the last stage this edge.
  // A stalled pipe only loses an entry when stage 0 is flushed.
  always_comb begin
    entering = 1'b0;
    leaving  = 1'b0;
    if (stall) begin
      leaving = flush & v[0];
    end else begin
      entering = valid_i & ~flush;
      leaving  = v[DEPTH-1];
    end
  end

  // Next state: reset > flush (stage 0) > stall > shift.
  always_comb begin
    dataNext = data;
    vNext    = v;
    occNext  = occ;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dataNext[i] = BUBBLE_VAL;
      end
      vNext   = '0;
      occNext = '0;
    end else begin
      if (!stall) begin
        for (int i = 1; i < DEPTH; i++) begin
          dataNext[i] = data[i-1];
          vNext[i]    = v[i-1];
        end
        dataNext[0] = d;
        vNext[0]    = valid_i;
      end
      if (flush) begin
        dataNext[0] = BUBBLE_VAL;
        vNext[0]    = 1'b0;
      end
      if (entering && !leaving) begin
        occNext = occ + OW'(1);
      end else if (leaving && !entering) begin
        occNext = occ - OW'(1);
      end
    end
  end

  // State register on the selected clock edge.
  if (NEG_EDGE) begin : gNeg
    always_ff @(negedge clk) begin
      data <= dataNext;
      v    <= vNext;
      occ  <= occNext;
    end
  end else begin : gPos
    always_ff @(posedge clk) begin
      data <= dataNext;
      v    <= vNext;
      occ  <= occNext;
    end
  end

  assign q         = data[DEPTH-1];
  assign valid_o   = v[DEPTH-1];
  assign occupancy = occ;

endmodule
